// File: rtl/dcm_prog_ctrl.sv
// Configuration controller for the programmable clock divider: turns incr/decr/load
// requests into a target selection, issues it with an update pulse and confirms it via readback.
module dcm_prog_ctrl #(
    parameter int unsigned CONFIRM_CYC = 4,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned MIN_GAP     = 16,
    parameter bit          WRAP        = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       incr,
    input  logic       decr,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic [2:0] prog_fb,
    output logic [2:0] prog,
    output logic       update,
    output logic [2:0] target,
    output logic       busy,
    output logic       err
);

    localparam int unsigned WAIT_W  = (CONFIRM_CYC > 1) ? $clog2(CONFIRM_CYC) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [2:0]         target_q, target_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               err_q, err_d;
    logic               update_q, update_d;
    logic               busy_q, busy_d;
    logic               incr_q, decr_q, load_q;

    logic       ev_incr, ev_decr, ev_load;
    logic       sel_valid;
    logic [2:0] sel_t;

    assign ev_incr = incr & ~incr_q;
    assign ev_decr = decr & ~decr_q;
    assign ev_load = load & ~load_q;

    // Prioritised new selection; a simultaneous incr/decr pair cancels out.
    always_comb begin
        sel_valid = 1'b0;
        sel_t     = target_q;
        if (ev_load) begin
            sel_valid = 1'b1;
            sel_t     = load_val;
        end else if (ev_incr && !ev_decr) begin
            sel_valid = 1'b1;
            if (target_q == 3'd7) sel_t = WRAP ? 3'd0 : 3'd7;
            else                  sel_t = target_q + 3'd1;
        end else if (ev_decr && !ev_incr) begin
            sel_valid = 1'b1;
            if (target_q == 3'd0) sel_t = WRAP ? 3'd7 : 3'd0;
            else                  sel_t = target_q - 3'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        retry_d  = retry_q;
        wait_d   = wait_q;
        gap_d    = gap_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (sel_valid && (sel_t != target_q)) begin
                    target_d = sel_t;
                    retry_d  = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (prog_fb == target_q) begin
                    gap_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_GAP;
                end else if (wait_q == WAIT_W'(CONFIRM_CYC - 1)) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(MIN_GAP - 1)) state_d = S_IDLE;
                else                              gap_d   = gap_q + GAP_W'(1);
            end
            S_ERR: begin
                // Only a direct load recovers, even when it repeats the failed value.
                if (ev_load) begin
                    target_d = load_val;
                    retry_d  = '0;
                    state_d  = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        update_d = (state_d == S_ISSUE);
        busy_d   = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_GAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= 3'd0;
            retry_q  <= '0;
            wait_q   <= '0;
            gap_q    <= '0;
            err_q    <= 1'b0;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
            incr_q   <= 1'b0;
            decr_q   <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            wait_q   <= wait_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
            update_q <= update_d;
            busy_q   <= busy_d;
            incr_q   <= incr;
            decr_q   <= decr;
            load_q   <= load;
        end
    end

    assign prog   = target_q;
    assign target = target_q;
    assign update = update_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Bench for dcm_prog_ctrl: saturating and wrapping instances share stimulus and are
// checked every cycle against a transaction-timeline reference model.
module tb_dcm_prog_ctrl;

    localparam int CC        = 4;
    localparam int MR        = 3;
    localparam int MG        = 16;
    localparam int PER       = CC + 1;
    localparam int OK_END    = 3 + MG;
    localparam int FAIL_END  = (MR + 1) * PER + 1;

    logic       clk = 1'b0;
    logic       rst, incr, decr, load;
    logic [2:0] load_val;
    logic       stuck;
    logic [2:0] stuck_val;

    logic [2:0] div_q  [2];
    logic [2:0] fb     [2];
    logic [2:0] prog   [2];
    logic [2:0] target [2];
    logic       update [2];
    logic       busy   [2];
    logic       err    [2];

    always #5 clk = ~clk;

    dcm_prog_ctrl #(.CONFIRM_CYC(CC), .MAX_RETRY(MR), .MIN_GAP(MG), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .incr(incr), .decr(decr), .load(load), .load_val(load_val),
        .prog_fb(fb[0]), .prog(prog[0]), .update(update[0]), .target(target[0]),
        .busy(busy[0]), .err(err[0])
    );

    dcm_prog_ctrl #(.CONFIRM_CYC(CC), .MAX_RETRY(MR), .MIN_GAP(MG), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .incr(incr), .decr(decr), .load(load), .load_val(load_val),
        .prog_fb(fb[1]), .prog(prog[1]), .update(update[1]), .target(target[1]),
        .busy(busy[1]), .err(err[1])
    );

    // Divider model: latches prog on update; readback can be forced stuck.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q[0] <= 3'd0;
            div_q[1] <= 3'd0;
        end else begin
            if (update[0]) div_q[0] <= prog[0];
            if (update[1]) div_q[1] <= prog[1];
        end
    end
    assign fb[0] = stuck ? stuck_val : div_q[0];
    assign fb[1] = stuck ? stuck_val : div_q[1];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int upd_cnt[2];
    int busy_cnt[2];

    int m_tgt [2];
    bit m_err [2];
    bit m_act [2];
    bit m_inerr [2];
    bit m_fail [2];
    int m_t0 [2];
    bit p_incr, p_decr, p_load;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_tgt[i] = 0; m_err[i] = 0; m_act[i] = 0; m_inerr[i] = 0; m_fail[i] = 0; m_t0[i] = 0;
        end
        p_incr = 0; p_decr = 0; p_load = 0;
    endtask

    // Expected outputs follow from time elapsed since the accepting cycle.
    task automatic model_cycle(input int i, input bit el, input bit ei, input bit ed);
        int rel;
        int nt;
        bit have;
        bit exp_u, exp_b, exp_e;
        rel = cyc - m_t0[i];
        if (m_act[i] && !m_fail[i] && rel >= OK_END) begin
            m_act[i] = 0; m_err[i] = 0; m_inerr[i] = 0;
        end
        if (m_act[i] && m_fail[i] && rel >= FAIL_END) begin
            m_act[i] = 0; m_err[i] = 1; m_inerr[i] = 1;
        end
        exp_u = 0; exp_b = 0; exp_e = m_err[i];
        if (m_act[i]) begin
            if (!m_fail[i]) begin
                exp_u = (rel == 1);
                exp_b = (rel >= 1) && (rel <= OK_END - 1);
                if (rel >= 3) exp_e = 0;
            end else begin
                exp_u = (rel >= 1) && (rel <= 1 + MR * PER) && ((rel - 1) % PER == 0);
                exp_b = (rel >= 1) && (rel <= FAIL_END - 1);
            end
        end
        check($sformatf("target%0d", i), 32'(target[i]), 32'(m_tgt[i]));
        check($sformatf("prog%0d", i),   32'(prog[i]),   32'(m_tgt[i]));
        check($sformatf("update%0d", i), 32'(update[i]), 32'(exp_u));
        check($sformatf("busy%0d", i),   32'(busy[i]),   32'(exp_b));
        check($sformatf("err%0d", i),    32'(err[i]),    32'(exp_e));
        if (!m_act[i]) begin
            have = 0;
            nt   = m_tgt[i];
            if (el) begin
                have = 1; nt = int'(load_val);
            end else if (!m_inerr[i]) begin
                if (ei && !ed) begin
                    have = 1; nt = (m_tgt[i] == 7) ? ((i == 1) ? 0 : 7) : m_tgt[i] + 1;
                end else if (ed && !ei) begin
                    have = 1; nt = (m_tgt[i] == 0) ? ((i == 1) ? 7 : 0) : m_tgt[i] - 1;
                end
            end
            if (have && (m_inerr[i] || nt != m_tgt[i])) begin
                m_tgt[i]  = nt;
                m_act[i]  = 1;
                m_t0[i]   = cyc;
                m_fail[i] = stuck && (int'(stuck_val) != nt);
            end
        end
    endtask

    task automatic step(input bit i_incr, input bit i_decr, input bit i_load, input logic [2:0] lv);
        bit el, ei, ed;
        @(posedge clk);
        #1;
        incr = i_incr; decr = i_decr; load = i_load; load_val = lv;
        @(negedge clk);
        el = load & ~p_load;
        ei = incr & ~p_incr;
        ed = decr & ~p_decr;
        for (int i = 0; i < 2; i++) begin
            upd_cnt[i]  += int'(update[i]);
            busy_cnt[i] += int'(busy[i]);
            model_cycle(i, el, ei, ed);
        end
        p_incr = incr; p_decr = decr; p_load = load;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 3'd0);
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 2; i++) begin
            upd_cnt[i] = 0; busy_cnt[i] = 0;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1; incr = 0; decr = 0; load = 0; load_val = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_reset();
    endtask

    task automatic single_incr_scenario(input string tag);
        clr_cnt();
        step(1, 0, 0, 3'd0);
        idle(25);
        check({tag, "_tgt"},  32'(target[0]), 32'd1);
        check({tag, "_upd"},  32'(upd_cnt[0]), 32'd1);
        check({tag, "_busy"}, 32'(busy_cnt[0]), 32'(2 + MG));
        check({tag, "_err"},  32'(err[0]), 32'd0);
    endtask

    initial begin
        rst = 1; incr = 0; decr = 0; load = 0; load_val = 3'd0;
        stuck = 0; stuck_val = 3'd0;
        m_reset();
        clr_cnt();
        #1;
        check("rst_tgt", 32'(target[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Single increment with a working loop.
        single_incr_scenario("s1");

        // Saturate vs wrap over eight increments.
        apply_reset();
        clr_cnt();
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 3'd0);
            idle(22);
        end
        check("sat_tgt", 32'(target[0]), 32'd7);
        check("sat_upd", 32'(upd_cnt[0]), 32'd7);
        check("wrap_tgt", 32'(target[1]), 32'd0);
        check("wrap_upd", 32'(upd_cnt[1]), 32'd8);

        // Load beats incr; incr with decr cancels.
        clr_cnt();
        step(1, 0, 1, 3'd5);
        idle(22);
        check("ld_pri_tgt", 32'(target[0]), 32'd5);
        check("ld_pri_upd", 32'(upd_cnt[0]), 32'd1);
        clr_cnt();
        step(1, 1, 0, 3'd0);
        idle(22);
        check("cancel_tgt", 32'(target[1]), 32'd5);
        check("cancel_upd", 32'(upd_cnt[0] + upd_cnt[1]), 32'd0);

        // Stuck readback: four attempts then sticky error; working loop clears it.
        clr_cnt();
        stuck = 1; stuck_val = 3'd0;
        step(0, 0, 1, 3'd3);
        idle(25);
        check("stuck_upd", 32'(upd_cnt[0]), 32'(MR + 1));
        check("stuck_err", 32'(err[0]), 32'd1);
        check("stuck_busy", 32'(busy[0]), 32'd0);
        stuck = 0;
        step(0, 0, 1, 3'd3);
        idle(22);
        check("recover_err", 32'(err[0]), 32'd0);
        check("recover_tgt", 32'(target[0]), 32'd3);

        // Edge during GAP dropped, edge in first IDLE cycle accepted.
        step(1, 0, 0, 3'd0);
        idle(9);
        step(1, 0, 0, 3'd0);
        idle(8);
        step(1, 0, 0, 3'd0);
        idle(22);
        check("gap_tgt", 32'(target[0]), 32'd5);

        // Reset in WAIT of an error-recovery attempt.
        stuck = 1; stuck_val = 3'd0;
        step(0, 0, 1, 3'd6);
        idle(24);
        step(0, 0, 1, 3'd6);
        idle(2);
        check("pre_rst_err", 32'(err[0]), 32'd1);
        @(posedge clk);
        #1 rst = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("arst_upd%0d", i),  32'(update[i]), 32'd0);
            check($sformatf("arst_tgt%0d", i),  32'(target[i]), 32'd0);
            check($sformatf("arst_busy%0d", i), 32'(busy[i]),   32'd0);
            check($sformatf("arst_err%0d", i),  32'(err[i]),    32'd0);
        end
        stuck = 0;
        incr = 0; decr = 0; load = 0;
        @(posedge clk);
        #1 rst = 0;
        m_reset();
        single_incr_scenario("s6");

        // Randomised traffic with occasional stuck readback.
        for (int k = 0; k < 3000; k++) begin
            bit ni, nd, nl;
            ni = ($urandom_range(0, 3) == 0) ? ~incr : incr;
            nd = ($urandom_range(0, 3) == 0) ? ~decr : decr;
            nl = ($urandom_range(0, 5) == 0) ? ~load : load;
            if (!m_act[0] && !m_act[1] && ($urandom_range(0, 40) == 0)) begin
                stuck     = ($urandom_range(0, 2) == 0);
                stuck_val = 3'($urandom);
            end
            step(ni, nd, nl, 3'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/dcm_prog_ctrl.md
Name: dcm_prog_ctrl

Overview:
- Configuration controller for the programmable clock divider (dcm).
- Turns user requests (increment, decrement, direct load) into a target divider selection.
- Issues it to the divider as a prog value plus a one-cycle update pulse, then confirms the change through the divider's prog_out readback.
- Retries on a missing confirmation, flags a sticky error after repeated failures, and enforces a hold-off gap between reconfigurations.

Parameters:
- CONFIRM_CYC, 4: cycles to wait in WAIT for prog_fb to match the target before a retry.
- MAX_RETRY, 3: re-issues allowed after the first attempt before entering ERR.
- MIN_GAP, 16: hold-off cycles in GAP after a confirmed update.
- WRAP, 0: 0 = saturate at 0/7; 1 = wrap 7->0 and 0->7.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- incr  in  1  level request; its rising edge steps the target up.
- decr  in  1  level request; its rising edge steps the target down.
- load  in  1  level request; its rising edge sets the target to load_val.
- load_val  in  3  value used for a direct load.
- prog_fb  in  3  readback from the divider's prog_out.
- prog  out  3  value driven to the divider's prog input; always equals target.
- update  out  1  one-cycle pulse to the divider's update input.
- target  out  3  currently requested selection.
- busy  out  1  high in ISSUE, WAIT and GAP.
- err  out  1  sticky confirmation-failure flag.

Behaviour:
- Reset (asynchronous, immediate): target=0, prog=0, update=0, busy=0, err=0, state=IDLE, all counters=0, edge registers=0. Reset mid-transaction aborts it; update drops without waiting for a clock edge.
- Edge detection: incr_d, decr_d and load_d are registered every cycle. An event is X & ~X_d, evaluated combinationally in the first cycle X is high.
- Event priority: load > incr > decr.
- Simultaneous incr and decr without load: both ignored.
- Events arriving while busy=1 are dropped, not queued.
- Step arithmetic (3-bit): incr at 7 stays 7 if WRAP=0, becomes 0 if WRAP=1. decr at 0 stays 0 if WRAP=0, becomes 7 if WRAP=1.
- States: IDLE, ISSUE, WAIT, GAP, ERR.
- IDLE:
  - On an accepted event, compute new_t.
  - new_t == target: no transaction; stay in IDLE.
  - Otherwise: target<=new_t, retry_cnt<=0, go to ISSUE.
- ISSUE:
  - Lasts exactly one cycle with update=1 (Moore output); prog equals target.
  - wait_cnt<=0, go to WAIT.
- WAIT:
  - If prog_fb == target: go to GAP with gap_cnt<=0, and clear err.
  - Else if wait_cnt == CONFIRM_CYC-1 and retry_cnt < MAX_RETRY: retry_cnt+1, go to ISSUE.
  - Else if wait_cnt == CONFIRM_CYC-1 and retry_cnt == MAX_RETRY: err<=1, go to ERR.
  - Otherwise wait_cnt+1.
- GAP: count MIN_GAP cycles, then go to IDLE.
- ERR:
  - busy=0, err=1.
  - incr and decr are ignored.
  - A load event sets target<=load_val (even if equal to the old target), retry_cnt<=0, and goes to ISSUE; err stays 1 until a confirmation.
- Latency:
  - Event seen in cycle c, update high in cycle c+1.
  - The divider latches prog at the end of c+1, so prog_fb matches in cycle c+2.
  - GAP is entered at c+3 and IDLE at c+3+MIN_GAP.
- Error timing: a permanently stuck prog_fb gives (MAX_RETRY+1) update pulses, then err=1.
- Counter widths: sized by $clog2 of the respective parameter, minimum 1 bit.

Test Plan:
1. Reset, then an incr pulse with prog_fb looped from a divider model -> target=1; update high exactly 1 cycle, 1 cycle after the edge; busy high for 2+MIN_GAP cycles; err=0.
2. Seven incr edges spaced beyond the gap, then one more (WRAP=0) -> target reaches 7 and stays 7; the 8th edge produces no update. Same sequence with WRAP=1 -> target returns to 0.
3. load with load_val=5 and incr rising in the same cycle -> target=5, single update; incr and decr together -> no change and no update.
4. prog_fb held at 0, load 3 -> 4 update pulses spaced CONFIRM_CYC+1 cycles apart, then err=1 and busy=0. A later load 3 with a working loop -> err clears at confirmation.
5. incr edge during GAP -> dropped, target unchanged. incr edge in the first IDLE cycle -> accepted.
6. rst asserted mid-WAIT -> update=0, target=0, busy=0, err=0 immediately. The first post-reset incr behaves as in scenario 1.
